// File: rtl/load_store_ctrl_pkg.sv
// Shared definitions for the data-memory path: access size encodings,
// load/store controller state encoding and the registered request control bits.
package load_store_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic      write;
    mem_size_e size;
    logic      sign;
  } req_ctrl_t;

  localparam req_ctrl_t REQ_CTRL_RESET = '{write: 1'b0, size: SIZE_BYTE, sign: 1'b0};

endpackage

// File: rtl/load_store_ctrl_align_checker.sv
// Combinational natural-alignment check for a data-memory access.
// Size 11 has no legal alignment and always faults.
module align_checker
  import load_store_ctrl_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic       misaligned
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
    misaligned = 1'b0;
    unique case (mem_size_e'(size))
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr[0];
      SIZE_WORD: misaligned = |addr;
      default:   misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store controller between EX/MEM and a combinational data memory.
// Each request takes one ACCESS cycle followed by a held response in RESP.
module load_store_ctrl
  import load_store_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_sign,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [1:0]               mem_size,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  output logic                     mem_sign_ext,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_misaligned
);

  lsu_state_e                state_q, state_d;
  logic                      started_q;
  req_ctrl_t                 ctrl_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      misaligned_q;
  logic                      misaligned;
  logic                      accept;

  align_checker u_align_checker (
    .size       (ctrl_q.size),
    .addr       (addr_q[1:0]),
    .misaligned (misaligned)
  );

  assign accept = req_valid && req_ready;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keeps req_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = started_q;
      ACCESS:  mem_we    = ctrl_q.write && !misaligned;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
      end
      default: ;
    endcase
  end

  // NOTE: these request registers feed mem_* directly, so they are reset to give defined outputs in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= REQ_CTRL_RESET;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ctrl_q  <= '{write: req_write, size: mem_size_e'(req_size), sign: req_sign};
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // The registered request only changes on acceptance, which is also the only
  // way into ACCESS, so mem_* hold their last value outside ACCESS.
  assign mem_size     = ctrl_q.size;
  assign mem_addr     = addr_q;
  assign mem_din      = wdata_q;
  assign mem_sign_ext = ctrl_q.sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      misaligned_q <= misaligned;
      rdata_q      <= (!ctrl_q.write && !misaligned) ? mem_dout : '0;
    end
  end

  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = misaligned_q;

endmodule
